// File: rtl/uart_cmd_if.sv
// Signal bundle between the drive-command UART receiver and its line/motor-driver side.
// The slave modport is the receiver's view; the master modport drives the line and reads the decoded command.
interface uart_cmd_if;
  logic       uart_in;
  logic [3:0] move_cmd;
  logic [3:0] speed_level;
  logic       cmd_valid;
  logic       frame_err;
  logic       link_timeout;

  modport master (
    output uart_in,
    input  move_cmd, speed_level, cmd_valid, frame_err, link_timeout
  );

  modport slave (
    input  uart_in,
    output move_cmd, speed_level, cmd_valid, frame_err, link_timeout
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that decodes each byte into a latched move_cmd/speed_level pair,
// with a link watchdog that forces STOP when accepted frames stop arriving.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 25_000_000
) (
  input logic       clk,
  input logic       rst,
  uart_cmd_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int WD_W  = $clog2(TIMEOUT_CLKS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);
  localparam logic [3:0]       MOVE_STOP = 4'b1000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_armed;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [3:0]       r_move;
  logic [3:0]       r_speed;
  logic             r_cmd_valid;
  logic             r_frame_err;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_timeout;

  logic w_code_legal;
  logic w_stop_sample;
  logic w_accept;

  assign w_code_legal  = (r_shift[3:0] <= 4'd8);
  assign w_stop_sample = (r_state == S_STOP) && (r_bit_cnt == BIT_LAST);
  assign w_accept      = w_stop_sample && r_sync2 && w_code_legal;

  // r_armed blocks a new start until the line has been seen high, so a stuck-low
  // line or a reset released mid-frame cannot retrigger the receiver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_armed     <= 1'b0;
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'd0;
      r_move      <= MOVE_STOP;
      r_speed     <= 4'd0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= bus.uart_in;
      r_sync2     <= r_sync1;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_sync2) r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!r_sync2 && r_armed) begin
            r_state   <= S_START;
            r_bit_cnt <= '0;
          end
        end
        S_START: begin
          if (r_bit_cnt == HALF_LAST) begin
            r_bit_cnt <= '0;
            r_idx     <= 3'd0;
            r_state   <= r_sync2 ? S_IDLE : S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt      <= '0;
            r_shift[r_idx] <= r_sync2;
            if (r_idx == 3'd7) r_state <= S_STOP;
            else               r_idx   <= r_idx + 3'd1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (w_stop_sample) begin
            r_bit_cnt <= '0;
            if (w_accept) begin
              r_state     <= S_DONE;
              r_cmd_valid <= 1'b1;
              r_move      <= r_shift[3:0];
              r_speed     <= r_shift[7:4];
            end else begin
              r_state     <= S_IDLE;
              r_frame_err <= 1'b1;
              if (!r_sync2) r_armed <= 1'b0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Watchdog: an accepted frame always wins over expiry in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (!r_timeout) begin
      if (r_wd_cnt == WD_LAST) r_timeout <= 1'b1;
      else                     r_wd_cnt  <= r_wd_cnt + WD_ONE;
    end
  end

  assign bus.move_cmd     = r_timeout ? MOVE_STOP : r_move;
  assign bus.speed_level  = r_speed;
  assign bus.cmd_valid    = r_cmd_valid;
  assign bus.frame_err    = r_frame_err;
  assign bus.link_timeout = r_timeout;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: drives 8N1 frames and compares the decoded outputs, pulse counts and
// watchdog timing against a frame-level model of the command link.
module tb_uart_cmd_rx;
  localparam int CPB = 434;
  localparam int TMO = 10_000;
  // Accept is visible 2 sync flops + 1 register after the middle of the stop bit.
  localparam int ACC_LAT = 9 * CPB + CPB / 2 + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_cmd_if bus_if ();

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_valid = 0, n_err = 0, last_valid_cyc = 0;
  int n_vec = 0, n_bad = 0;

  // Frame-level reference model state.
  logic [3:0] exp_move = 4'd8;
  logic [3:0] exp_speed = 4'd0;
  int exp_valid = 0, exp_err = 0;
  int model_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.cmd_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (bus_if.frame_err) n_err++;
  end

  function automatic logic exp_to_now();
    return (cyc - model_acc_cyc) >= TMO;
  endfunction

  function automatic logic [3:0] exp_move_now();
    return exp_to_now() ? 4'd8 : exp_move;
  endfunction

  // Must be called on a negedge; returns on a negedge at the end of the frame.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    bus_if.uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_if.uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus_if.uart_in = stop_bit;
    repeat (CPB) @(negedge clk);
    bus_if.uart_in = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk);
    if (stop_bit && b[3:0] <= 4'd8) begin
      exp_valid++;
      exp_move = b[3:0];
      exp_speed = b[7:4];
      model_acc_cyc = start_cyc + ACC_LAT;
    end else begin
      exp_err++;
    end
    $display("tx byte=%h stop=%0d start_cyc=%0d valid=%0d err=%0d", b, stop_bit, start_cyc, n_valid, n_err);
  endtask

  task automatic test_reset;
    bus_if.uart_in = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (bus_if.move_cmd !== 4'd8 || bus_if.speed_level !== 4'd0 || bus_if.link_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vals: got move=%h speed=%h to=%b want 8 0 0", bus_if.move_cmd, bus_if.speed_level, bus_if.link_timeout);
    end
    rst = 1'b0;
    model_acc_cyc = cyc;
    repeat (20 * CPB) @(negedge clk);
    n_vec++;
    if (n_valid !== 0 || n_err !== 0) begin
      n_bad++;
      $display("FAIL idle_pulses: got valid=%0d err=%0d want 0 0", n_valid, n_err);
    end
    n_vec++;
    if (bus_if.move_cmd !== 4'd8 || bus_if.speed_level !== 4'd0 || bus_if.link_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_outputs: got move=%h speed=%h to=%b want 8 0 0", bus_if.move_cmd, bus_if.speed_level, bus_if.link_timeout);
    end
  endtask

  task automatic test_single;
    int s;
    send_byte(8'h52, 1'b1, s);
    n_vec++;
    if (n_valid !== exp_valid) begin
      n_bad++;
      $display("FAIL single_count: got %0d want %0d", n_valid, exp_valid);
    end
    n_vec++;
    if (last_valid_cyc - s < ACC_LAT - 6 || last_valid_cyc - s > ACC_LAT + 6) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want %0d+-6", last_valid_cyc - s, ACC_LAT);
    end
    n_vec++;
    if (bus_if.move_cmd !== 4'b0010 || bus_if.speed_level !== 4'b0101) begin
      n_bad++;
      $display("FAIL single_outputs: got move=%h speed=%h want 2 5", bus_if.move_cmd, bus_if.speed_level);
    end
  endtask

  task automatic test_back_to_back;
    int s;
    send_byte(8'h37, 1'b1, s);
    send_byte(8'h18, 1'b1, s);
    n_vec++;
    if (n_valid !== exp_valid || n_err !== exp_err) begin
      n_bad++;
      $display("FAIL b2b_count: got valid=%0d err=%0d want %0d %0d", n_valid, n_err, exp_valid, exp_err);
    end
    n_vec++;
    if (bus_if.move_cmd !== 4'b1000 || bus_if.speed_level !== 4'b0001) begin
      n_bad++;
      $display("FAIL b2b_outputs: got move=%h speed=%h want 8 1", bus_if.move_cmd, bus_if.speed_level);
    end
  endtask

  task automatic test_errors;
    int s;
    int v0;
    v0 = n_valid;
    send_byte(8'h09, 1'b1, s);
    n_vec++;
    if (n_err !== exp_err || n_valid !== v0) begin
      n_bad++;
      $display("FAIL illegal_code: got err=%0d valid=%0d want %0d %0d", n_err, n_valid, exp_err, v0);
    end
    n_vec++;
    if (bus_if.move_cmd !== exp_move_now() || bus_if.speed_level !== exp_speed) begin
      n_bad++;
      $display("FAIL illegal_hold: got move=%h speed=%h want %h %h", bus_if.move_cmd, bus_if.speed_level, exp_move_now(), exp_speed);
    end
    send_byte(8'h40, 1'b0, s);
    n_vec++;
    if (n_err !== exp_err || n_valid !== v0) begin
      n_bad++;
      $display("FAIL bad_stop: got err=%0d valid=%0d want %0d %0d", n_err, n_valid, exp_err, v0);
    end
    n_vec++;
    if (bus_if.move_cmd !== exp_move_now() || bus_if.speed_level !== exp_speed) begin
      n_bad++;
      $display("FAIL bad_stop_hold: got move=%h speed=%h want %h %h", bus_if.move_cmd, bus_if.speed_level, exp_move_now(), exp_speed);
    end
  endtask

  task automatic test_glitch;
    bus_if.uart_in = 1'b0;
    repeat (100) @(negedge clk);
    bus_if.uart_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    $display("tx glitch 100 cycles valid=%0d err=%0d", n_valid, n_err);
    n_vec++;
    if (n_valid !== exp_valid || n_err !== exp_err) begin
      n_bad++;
      $display("FAIL glitch: got valid=%0d err=%0d want %0d %0d", n_valid, n_err, exp_valid, exp_err);
    end
  endtask

  task automatic test_timeout;
    int s;
    int t0;
    send_byte(8'h73, 1'b1, s);
    t0 = last_valid_cyc;
    n_vec++;
    if (n_valid !== exp_valid || bus_if.link_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL to_accept: got valid=%0d to=%b want %0d 0", n_valid, bus_if.link_timeout, exp_valid);
    end
    for (int i = 0; i < TMO + 500 && !bus_if.link_timeout; i++) @(negedge clk);
    n_vec++;
    if (bus_if.link_timeout !== 1'b1 || cyc - t0 !== TMO) begin
      n_bad++;
      $display("FAIL to_rise: got to=%b after %0d cycles want 1 after %0d", bus_if.link_timeout, cyc - t0, TMO);
    end
    n_vec++;
    if (bus_if.move_cmd !== 4'b1000 || bus_if.speed_level !== 4'b0111) begin
      n_bad++;
      $display("FAIL to_outputs: got move=%h speed=%h want 8 7", bus_if.move_cmd, bus_if.speed_level);
    end
    send_byte(8'h21, 1'b1, s);
    n_vec++;
    if (bus_if.link_timeout !== 1'b0 || bus_if.move_cmd !== 4'b0001 || bus_if.speed_level !== 4'b0010) begin
      n_bad++;
      $display("FAIL to_clear: got to=%b move=%h speed=%h want 0 1 2", bus_if.link_timeout, bus_if.move_cmd, bus_if.speed_level);
    end
  endtask

  task automatic test_reset_mid_frame;
    int s;
    bus_if.uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    bus_if.uart_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    bus_if.uart_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    $display("tx reset mid-frame at cyc=%0d", cyc);
    n_vec++;
    if (bus_if.move_cmd !== 4'd8 || bus_if.speed_level !== 4'd0 || bus_if.link_timeout !== 1'b0 || bus_if.cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_vals: got move=%h speed=%h to=%b want 8 0 0", bus_if.move_cmd, bus_if.speed_level, bus_if.link_timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_if.uart_in = 1'b1;
    exp_move = 4'd8;
    exp_speed = 4'd0;
    model_acc_cyc = cyc;
    repeat (3 * CPB) @(negedge clk);
    send_byte(8'h52, 1'b1, s);
    n_vec++;
    if (n_valid !== exp_valid || n_err !== exp_err || bus_if.move_cmd !== 4'b0010 || bus_if.speed_level !== 4'b0101) begin
      n_bad++;
      $display("FAIL midreset_resync: got valid=%0d err=%0d move=%h speed=%h want %0d %0d 2 5",
               n_valid, n_err, bus_if.move_cmd, bus_if.speed_level, exp_valid, exp_err);
    end
  endtask

  task automatic test_random;
    int s;
    logic [7:0] b;
    logic sb;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send_byte(b, sb, s);
      n_vec++;
      if (n_valid !== exp_valid || n_err !== exp_err) begin
        n_bad++;
        $display("FAIL rand_count[%0d]: got valid=%0d err=%0d want %0d %0d", k, n_valid, n_err, exp_valid, exp_err);
      end
      n_vec++;
      if (bus_if.move_cmd !== exp_move_now() || bus_if.speed_level !== exp_speed || bus_if.link_timeout !== exp_to_now()) begin
        n_bad++;
        $display("FAIL rand_outputs[%0d]: got move=%h speed=%h to=%b want %h %h %b", k, bus_if.move_cmd,
                 bus_if.speed_level, bus_if.link_timeout, exp_move_now(), exp_speed, exp_to_now());
      end
    end
  endtask

  initial begin
    bus_if.uart_in = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART receiver for the drive-command link. It is the far end of the move_cmd/speed_level transmitter on the control FPGA.
- Sits on the motor-side board. It samples the serial line, checks each 8N1 frame, and decodes the byte into a latched move_cmd/speed_level pair for the motor driver.
- A link watchdog forces STOP if valid frames stop arriving, so the car never keeps driving on a dead link.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50_000_000/115_200).
- TIMEOUT_CLKS, 25_000_000, cycles without an accepted frame before a forced stop (0.5 s at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset, asynchronous, active-high
- uart_in  input  1  serial line, idle high, asynchronous to clk
- move_cmd  output  4  latched movement code
- speed_level  output  4  latched speed level
- cmd_valid  output  1  one-cycle pulse when a new command is accepted
- frame_err  output  1  one-cycle pulse on a bad stop bit or an illegal move code
- link_timeout  output  1  high while the watchdog has expired

Behaviour:
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Byte[3:0] = move_cmd. Byte[7:4] = speed_level.
- Legal move codes: 0000 fwd, 0001 fwd-left, 0010 fwd-right, 0011 reverse, 0100 spin CCW, 0101 spin CW, 0110 rev-left, 0111 rev-right, 1000 stop. Codes 1001..1111 are illegal.
- Input conditioning: uart_in passes through a 2-flop synchronizer. The FSM uses only the synchronized value, which adds 2 cycles of latency.
- Reset values: move_cmd=1000, speed_level=0000, cmd_valid=0, frame_err=0, link_timeout=0. The FSM resets to IDLE and all counters clear.
- FSM states:
  - IDLE: on synchronized line = 0, go to START and clear the bit counter.
  - START: wait (CLKS_PER_BIT-1)/2 cycles, then sample.
    - Sample 0: go to DATA.
    - Sample 1: glitch; return to IDLE with no pulse.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into shift register bit[idx]. After idx 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - 1 and legal code: go to DONE.
    - 0, or illegal code: pulse frame_err and go to IDLE.
  - DONE: for one cycle, update move_cmd/speed_level, pulse cmd_valid, reload the watchdog, then go to IDLE.
- Latency: cmd_valid and the new outputs appear exactly 1 cycle after the stop-bit sample cycle.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge that follows immediately is caught.
- Rejected frames: move_cmd/speed_level hold their previous values, and the watchdog is not reloaded.
- Watchdog:
  - Counter counts up every cycle. When it reaches TIMEOUT_CLKS-1, link_timeout goes high and move_cmd is forced to 1000; speed_level holds.
  - The counter saturates while link_timeout is high.
  - Only an accepted frame clears the counter and link_timeout; this happens in the same cycle as cmd_valid.
- Simultaneous events: if an accepted frame and watchdog expiry fall in the same cycle, the frame wins. Outputs take the frame, link_timeout stays 0, and the counter restarts.
- Reset mid-frame: asynchronous; outputs return to reset values immediately. A partial frame is discarded, and the receiver resyncs on the next falling edge after the line idles high.
- Line held low continuously: the frame fails its stop bit and pulses frame_err. The FSM then stays in IDLE until the line returns high and falls again, so frame_err pulses only once.
- Counter widths: $clog2(CLKS_PER_BIT) for the bit timer and $clog2(TIMEOUT_CLKS) for the watchdog. Neither counter wraps.

Test Plan:
- Reset then idle line: move_cmd=1000, speed_level=0, no pulses for 20 bit times.
- Send 0x52 at 434 clk/bit: exactly one cmd_valid, 1 cycle after the stop sample; move_cmd=0010, speed_level=0101.
- Send 0x37 then 0x18 with no idle gap: two cmd_valid pulses; final outputs are move_cmd=1000, speed_level=0001.
- Send 0x09 (illegal code 1001): one frame_err pulse, no cmd_valid, outputs unchanged. Send 0x40 with stop bit driven 0: one frame_err pulse, outputs unchanged.
- 100-cycle low glitch on idle line: no cmd_valid, no frame_err, FSM back in IDLE.
- TIMEOUT_CLKS=10_000:
  - Send 0x73, then stay idle: link_timeout rises 10_000 cycles after cmd_valid, move_cmd=1000, speed_level=0111.
  - Send 0x21: link_timeout clears, move_cmd=0001.
  - Assert rst mid-DATA: outputs reset immediately; the next full 0x52 frame decodes correctly.
